// File: rtl/instr_word_encoder.sv
// instr_word_encoder
//   Program loader for the RV32I single-cycle core. It accepts field-level
//   instruction requests on a valid/ready handshake. Each request is encoded
//   into a 32-bit RV32I word (R-type, load, store or branch). Words are
//   written to consecutive instruction-memory addresses, starting at BASE_ADDR
//   and wrapping modulo 2^ADDR_W.
//
// Parameters
//   ADDR_W     instruction-memory word-address width
//   DEPTH      maximum words per load session (1..2^ADDR_W)
//   BASE_ADDR  word address of the first instruction of a session
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   start, stop           one-cycle session control pulses (start wins)
//   in_valid / in_ready   request handshake
//   in_class              00 R-type, 01 load, 10 store, 11 branch
//   in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm   request fields
//   imem_we, imem_addr, imem_wdata   registered memory write port
//   count                 words written in the current session
//   full                  count == DEPTH
//   busy                  session active (LOAD or FULL)
module instr_word_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         enc_word;
    logic [ADDR_W:0]     count_inc;
    logic                accept;

    assign in_ready  = (state_q == LOAD) && !full_q && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + ONE_C;

    always_comb begin
        enc_word = '0;
        case (in_class)
            2'b00:   enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            2'b01:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            2'b10:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            default: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], 7'b1100011};
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // The write address is derived from count so a start needs no
        // separate pointer; the addition wraps naturally at 2^ADDR_W.
        if (accept) begin
            we_d    = 1'b1;
            addr_d  = BASE_C + count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_inc;
            full_d  = (count_inc == DEPTH_C);
        end

        // start blocks accepts via in_ready; stop still lets a coincident
        // beat through before leaving the session.
        if (start) begin
            state_d = LOAD;
            count_d = '0;
            full_d  = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
        end else if (accept && (count_inc == DEPTH_C)) begin
            state_d = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, in_valid;
    logic [1:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [12:0] in_imm;

    // instance 0: default parameters; instance 1: DEPTH=4, BASE_ADDR=254
    logic [1:0]  o_rdy, o_we, o_full, o_busy;
    logic [7:0]  o_addr [2];
    logic [31:0] o_wd   [2];
    logic [8:0]  o_cnt  [2];

    instr_word_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(o_rdy[0]), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(o_we[0]), .imem_addr(o_addr[0]), .imem_wdata(o_wd[0]),
        .count(o_cnt[0]), .full(o_full[0]), .busy(o_busy[0]));

    instr_word_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(o_rdy[1]), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(o_we[1]), .imem_addr(o_addr[1]), .imem_wdata(o_wd[1]),
        .count(o_cnt[1]), .full(o_full[1]), .busy(o_busy[1]));

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned P_DEPTH [2] = '{256, 4};
    int unsigned P_BASE  [2] = '{0, 254};

    // Reference model: a session flag plus a word counter; full is simply
    // count == DEPTH and busy is the session flag.
    bit          m_act [2];
    int unsigned m_cnt [2];
    bit          m_we  [2];
    int unsigned m_addr[2];
    int unsigned m_wd  [2];

    function automatic int unsigned bitof(int unsigned v, int unsigned k);
        return (v >> k) & 1;
    endfunction

    // RV32I encoding from the field layout, built with shifts and sums.
    function automatic int unsigned ref_enc(int unsigned cls, int unsigned rd,
        int unsigned rs1, int unsigned rs2, int unsigned f3, int unsigned f7,
        int unsigned imm);
        int unsigned common;
        common = (f3 << 12) + (rs1 << 15);
        case (cls)
            0: return 32'h33 + (rd << 7) + common + (rs2 << 20) + (f7 << 25);
            1: return 32'h03 + (rd << 7) + common + ((imm % 4096) << 20);
            2: return 32'h23 + ((imm % 32) << 7) + common + (rs2 << 20)
                      + (((imm / 32) % 128) << 25);
            default: return 32'h63 + (bitof(imm, 11) << 7) + (((imm / 2) % 16) << 8)
                      + common + (rs2 << 20) + (((imm / 32) % 64) << 25)
                      + (bitof(imm, 12) << 31);
        endcase
    endfunction

    task automatic chk(string name, int unsigned act, int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready before the edge, advance the model with the
    // inputs seen at the edge, then check every registered output.
    task automatic tick();
        bit          ready [2];
        bit          acc;
        int unsigned enc;
        #1;
        for (int i = 0; i < 2; i++) begin
            ready[i] = m_act[i] && (m_cnt[i] < P_DEPTH[i]) && !start;
            chk($sformatf("in_ready[%0d]", i), o_rdy[i], ready[i]);
        end
        enc = ref_enc(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0; m_cnt[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
            end else begin
                acc = in_valid && ready[i];
                m_we[i] = acc;
                if (acc) begin
                    m_addr[i] = (P_BASE[i] + m_cnt[i]) % 256;
                    m_wd[i]   = enc;
                    m_cnt[i]++;
                end
                if (start) begin
                    m_act[i] = 1; m_cnt[i] = 0;
                end else if (stop) begin
                    m_act[i] = 0;
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("imem_we[%0d]", i),    o_we[i],   m_we[i]);
            chk($sformatf("imem_addr[%0d]", i),  o_addr[i], m_addr[i]);
            chk($sformatf("imem_wdata[%0d]", i), o_wd[i],   m_wd[i]);
            chk($sformatf("count[%0d]", i),      o_cnt[i],  m_cnt[i]);
            chk($sformatf("full[%0d]", i),       o_full[i], m_cnt[i] == P_DEPTH[i]);
            chk($sformatf("busy[%0d]", i),       o_busy[i], m_act[i]);
        end
    endtask

    task automatic set_req(logic [1:0] c, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                           logic [2:0] f3, logic [6:0] f7, logic [12:0] imm);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vt [9];
    int unsigned wr_cnt;

    initial begin
        // fixed encodings, including ignored-field variants
        vt[0] = '{2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 13'h0000, 32'h403100B3};
        vt[1] = '{2'b01, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 13'h0004, 32'h00412283};
        vt[2] = '{2'b10, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 13'h0008, 32'h00512423};
        vt[3] = '{2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0010, 32'h00208863};
        vt[4] = '{2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h1FF0, 32'hFE2088E3};
        vt[5] = '{2'b01, 5'd5, 5'd2, 5'd31, 3'd2, 7'h7F, 13'h1004, 32'h00412283};
        vt[6] = '{2'b10, 5'd31, 5'd2, 5'd5, 3'd2, 7'h55, 13'h1008, 32'h00512423};
        vt[7] = '{2'b11, 5'd9, 5'd1, 5'd2, 3'd0, 7'h11, 13'h0011, 32'h00208863};
        vt[8] = '{2'b00, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 13'h1FFF, 32'h403100B3};

        reset = 1; start = 0; stop = 0; in_valid = 0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        reset = 0;
        tick();

        // table: back-to-back accepts, fixed expected words on the default instance
        pulse_start();
        in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            set_req(vt[i].cls, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].f3, vt[i].f7, vt[i].imm);
            tick();
            chk($sformatf("table_we[%0d]", i), o_we[0], 1);
            chk($sformatf("table_word[%0d]", i), o_wd[0], vt[i].exp_word);
        end
        in_valid = 0;
        tick();

        // fill: DEPTH=4 instance takes exactly 4 words at 254,255,0,1
        pulse_start();
        in_valid = 1; wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(2'(i), 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 7'(i), 13'(i * 4));
            tick();
            if (o_we[1]) wr_cnt++;
        end
        in_valid = 0;
        chk("fill_writes", wr_cnt, 4);
        chk("fill_full", o_full[1], 1);
        tick();
        chk("fill_ready", o_rdy[1], 0);
        pulse_start();
        chk("restart_count", o_cnt[1], 0);
        in_valid = 1;
        tick();
        chk("restart_addr", o_addr[1], 254);

        // stop coincident with an accept: word written, then session ends
        stop = 1;
        tick();
        stop = 0; in_valid = 0;
        chk("stop_we", o_we[0], 1);
        chk("stop_busy", o_busy[0], 0);
        tick();

        // reset mid-stream with valid high
        pulse_start();
        in_valid = 1;
        tick(); tick();
        reset = 1;
        tick();
        chk("rst_we", o_we[0], 0);
        chk("rst_wdata", o_wd[0], 0);
        reset = 0;
        tick();
        in_valid = 0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            set_req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 7'($urandom), 13'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
